// File: rtl/ahb_mtx_pkg.sv
// Shared encodings for the L1 AHB bus matrix.
// Imported by every matrix stage.
package ahb_mtx_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_INCR = 3'b001;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HOLD = 2'b01,
        ST_DATA = 2'b10
    } state_e;

endpackage

// File: rtl/ahb_mtx_input_stage_if.sv
// Master-layer and output-stage signals of one matrix input port.
// slave = the input stage, master = its environment.
interface ahb_mtx_input_stage_if #(
    parameter int AW = 32,
    parameter int UW = 32,
    parameter int DW = 32
);
    logic          HSELS;
    logic [AW-1:0] HADDRS;
    logic [UW-1:0] HAUSERS;
    logic [1:0]    HTRANSS;
    logic          HWRITES;
    logic [2:0]    HSIZES;
    logic [2:0]    HBURSTS;
    logic [3:0]    HPROTS;
    logic [3:0]    HMASTERS;
    logic          HMASTLOCKS;
    logic [DW-1:0] HWDATAS;
    logic [UW-1:0] HWUSERS;
    logic          HREADYS;
    logic          HREADYOUTS;
    logic [1:0]    HRESPS;

    logic          sel_ip;
    logic [AW-1:0] addr_ip;
    logic [UW-1:0] auser_ip;
    logic [1:0]    trans_ip;
    logic          write_ip;
    logic [2:0]    size_ip;
    logic [2:0]    burst_ip;
    logic [3:0]    prot_ip;
    logic [3:0]    master_ip;
    logic          mastlock_ip;
    logic [DW-1:0] wdata_ip;
    logic [UW-1:0] wuser_ip;
    logic          held_tran_ip;
    logic          active_ip;
    logic          hreadymux_ip;
    logic          readyout_ip;
    logic [1:0]    resp_ip;

    modport slave (
        input  HSELS, HADDRS, HAUSERS, HTRANSS, HWRITES, HSIZES,
        input  HBURSTS, HPROTS, HMASTERS, HMASTLOCKS,
        input  HWDATAS, HWUSERS, HREADYS,
        input  active_ip, hreadymux_ip, readyout_ip, resp_ip,
        output HREADYOUTS, HRESPS,
        output sel_ip, addr_ip, auser_ip, trans_ip, write_ip,
        output size_ip, burst_ip, prot_ip, master_ip, mastlock_ip,
        output wdata_ip, wuser_ip, held_tran_ip
    );

    modport master (
        output HSELS, HADDRS, HAUSERS, HTRANSS, HWRITES, HSIZES,
        output HBURSTS, HPROTS, HMASTERS, HMASTLOCKS,
        output HWDATAS, HWUSERS, HREADYS,
        output active_ip, hreadymux_ip, readyout_ip, resp_ip,
        input  HREADYOUTS, HRESPS,
        input  sel_ip, addr_ip, auser_ip, trans_ip, write_ip,
        input  size_ip, burst_ip, prot_ip, master_ip, mastlock_ip,
        input  wdata_ip, wuser_ip, held_tran_ip
    );

endinterface

// File: rtl/ahb_mtx_hold_reg.sv
// Address-phase holding register with live/held output select.
// A held SEQ beat is replayed as NONSEQ INCR.
module ahb_mtx_hold_reg
    import ahb_mtx_pkg::*;
#(
    parameter int AW = 32,
    parameter int UW = 32
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          capture,
    input  logic          use_held,
    input  logic          sel,
    input  logic [AW-1:0] addr,
    input  logic [UW-1:0] auser,
    input  logic [1:0]    trans,
    input  logic          write,
    input  logic [2:0]    size,
    input  logic [2:0]    burst,
    input  logic [3:0]    prot,
    input  logic [3:0]    master,
    input  logic          mastlock,
    output logic          sel_ip,
    output logic [AW-1:0] addr_ip,
    output logic [UW-1:0] auser_ip,
    output logic [1:0]    trans_ip,
    output logic          write_ip,
    output logic [2:0]    size_ip,
    output logic [2:0]    burst_ip,
    output logic [3:0]    prot_ip,
    output logic [3:0]    master_ip,
    output logic          mastlock_ip
);

    logic          sel_q;
    logic [AW-1:0] addr_q;
    logic [UW-1:0] auser_q;
    logic [1:0]    trans_q;
    logic          write_q;
    logic [2:0]    size_q;
    logic [2:0]    burst_q;
    logic [3:0]    prot_q;
    logic [3:0]    master_q;
    logic          mastlock_q;
    logic          is_seq;

    // Once the beat is detached from its burst, the slave must see it as a fresh start.
    assign is_seq = (trans == HTRANS_SEQ);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_q      <= 1'b0;
            addr_q     <= '0;
            auser_q    <= '0;
            trans_q    <= HTRANS_IDLE;
            write_q    <= 1'b0;
            size_q     <= '0;
            burst_q    <= '0;
            prot_q     <= '0;
            master_q   <= '0;
            mastlock_q <= 1'b0;
        end else if (capture) begin
            sel_q      <= sel;
            addr_q     <= addr;
            auser_q    <= auser;
            trans_q    <= is_seq ? HTRANS_NONSEQ : trans;
            write_q    <= write;
            size_q     <= size;
            burst_q    <= is_seq ? HBURST_INCR : burst;
            prot_q     <= prot;
            master_q   <= master;
            mastlock_q <= mastlock;
        end
    end

    assign sel_ip      = use_held ? sel_q      : sel;
    assign addr_ip     = use_held ? addr_q     : addr;
    assign auser_ip    = use_held ? auser_q    : auser;
    assign trans_ip    = use_held ? trans_q    : trans;
    assign write_ip    = use_held ? write_q    : write;
    assign size_ip     = use_held ? size_q     : size;
    assign burst_ip    = use_held ? burst_q    : burst;
    assign prot_ip     = use_held ? prot_q     : prot;
    assign master_ip   = use_held ? master_q   : master;
    assign mastlock_ip = use_held ? mastlock_q : mastlock;

endmodule

// File: rtl/ahb_mtx_input_stage.sv
// Per-master input stage of the L1 AHB matrix: holds an ungranted
// address phase and returns the owning slave's data-phase response.
module ahb_mtx_input_stage
    import ahb_mtx_pkg::*;
#(
    parameter int AW = 32,
    parameter int UW = 32,
    parameter int DW = 32
) (
    input logic                  HCLK,
    input logic                  HRESETn,
    ahb_mtx_input_stage_if.slave bus
);

    state_e        state_q;
    state_e        state_d;
    state_e        addr_next;
    logic          trans_req;
    logic          accept;
    logic          capture;
    logic          hreadyout;
    logic [1:0]    hresp;
    logic [DW-1:0] wdata;

    assign trans_req = bus.HSELS & bus.HTRANSS[1] & bus.HREADYS;
    assign accept    = bus.active_ip & bus.hreadymux_ip;

    // Where a freshly presented address phase goes.
    assign addr_next = !trans_req ? ST_IDLE :
                       accept     ? ST_DATA : ST_HOLD;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        unique case (state_q)
            ST_IDLE: begin
                state_d = addr_next;
                capture = trans_req & ~accept;
            end
            ST_HOLD: begin
                hreadyout = 1'b0;
                if (accept) state_d = ST_DATA;
            end
            ST_DATA: begin
                hreadyout = bus.readyout_ip;
                hresp     = bus.resp_ip;
                if (bus.readyout_ip) begin
                    state_d = addr_next;
                    capture = trans_req & ~accept;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    ahb_mtx_hold_reg #(
        .AW (AW),
        .UW (UW)
    ) u_hold (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .capture     (capture),
        .use_held    (state_q == ST_HOLD),
        .sel         (bus.HSELS),
        .addr        (bus.HADDRS),
        .auser       (bus.HAUSERS),
        .trans       (bus.HTRANSS),
        .write       (bus.HWRITES),
        .size        (bus.HSIZES),
        .burst       (bus.HBURSTS),
        .prot        (bus.HPROTS),
        .master      (bus.HMASTERS),
        .mastlock    (bus.HMASTLOCKS),
        .sel_ip      (bus.sel_ip),
        .addr_ip     (bus.addr_ip),
        .auser_ip    (bus.auser_ip),
        .trans_ip    (bus.trans_ip),
        .write_ip    (bus.write_ip),
        .size_ip     (bus.size_ip),
        .burst_ip    (bus.burst_ip),
        .prot_ip     (bus.prot_ip),
        .master_ip   (bus.master_ip),
        .mastlock_ip (bus.mastlock_ip)
    );

    assign wdata         = bus.HWDATAS;
    assign bus.wdata_ip  = wdata;
    assign bus.wuser_ip  = bus.HWUSERS;

    assign bus.held_tran_ip = (state_q == ST_HOLD) | trans_req;
    assign bus.HREADYOUTS   = hreadyout;
    assign bus.HRESPS       = hresp;

    // The layer must keep HREADY low while a transfer is parked here.
    a_no_req_in_hold: assert property (
        @(posedge HCLK) disable iff (!HRESETn)
        (state_q == ST_HOLD) |-> !trans_req
    );

endmodule

// File: tb/tb_ahb_mtx_input_stage.sv
// Scoreboard bench for ahb_mtx_input_stage: directed plan plus
// random traffic against a transaction-level model.
module tb_ahb_mtx_input_stage;
    import ahb_mtx_pkg::*;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    ahb_mtx_input_stage_if #(.AW(32), .UW(32), .DW(32)) bus ();

    ahb_mtx_input_stage #(.AW(32), .UW(32), .DW(32)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    // Single-master layer: HREADY is this port's own HREADYOUT.
    assign bus.HREADYS = bus.HREADYOUTS;

    typedef struct packed {
        logic        sel;
        logic [31:0] addr;
        logic [31:0] auser;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic [3:0]  master;
        logic        mastlock;
    } ctl_t;

    typedef struct packed {
        ctl_t        ctl;
        logic [31:0] wdata;
        logic [31:0] wuser;
        logic        held_tran;
        logic        hreadyout;
        logic [1:0]  hresp;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model: a parked transfer (if any) and whether a slave owns a data phase.
    bit   m_parked;
    ctl_t m_park;
    bit   m_busy;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic ctl_t mk(logic sel, logic [31:0] addr, logic [1:0] trans,
                                logic write, logic [2:0] burst);
        ctl_t c;
        c.sel = sel; c.addr = addr; c.auser = 32'h00A5_0000 ^ addr;
        c.trans = trans; c.write = write; c.size = 3'd2; c.burst = burst;
        c.prot = 4'h3; c.master = 4'h5; c.mastlock = 1'b0;
        return c;
    endfunction

    task automatic apply(ctl_t c, logic [31:0] wd, logic [31:0] wu,
                         logic act, logic hrm, logic rdy, logic [1:0] rsp);
        bus.HSELS = c.sel;       bus.HADDRS = c.addr;   bus.HAUSERS = c.auser;
        bus.HTRANSS = c.trans;   bus.HWRITES = c.write; bus.HSIZES = c.size;
        bus.HBURSTS = c.burst;   bus.HPROTS = c.prot;   bus.HMASTERS = c.master;
        bus.HMASTLOCKS = c.mastlock;
        bus.HWDATAS = wd;        bus.HWUSERS = wu;
        bus.active_ip = act;     bus.hreadymux_ip = hrm;
        bus.readyout_ip = rdy;   bus.resp_ip = rsp;
    endtask

    task automatic cyc(ctl_t c, logic [31:0] wd, logic [31:0] wu,
                       logic act, logic hrm, logic rdy, logic [1:0] rsp);
        exp_t e;
        bit   req;
        bit   grant;
        ctl_t h;
        @(negedge HCLK);
        apply(c, wd, wu, act, hrm, rdy, rsp);
        #1;
        e.wdata = wd;
        e.wuser = wu;
        if (m_parked) begin
            e.ctl = m_park; e.held_tran = 1'b1;
            e.hreadyout = 1'b0; e.hresp = HRESP_OKAY;
            req = 1'b0;
        end else begin
            e.ctl = c;
            e.hreadyout = m_busy ? rdy : 1'b1;
            e.hresp = m_busy ? rsp : HRESP_OKAY;
            req = c.sel && c.trans[1] && e.hreadyout;
            e.held_tran = req;
        end
        q.push_back(e);
        grant = act && hrm;
        if (m_parked) begin
            if (grant) begin m_parked = 0; m_busy = 1; end
        end else if (!m_busy || rdy) begin
            m_busy = req && grant;
            if (req && !grant) begin
                h = c;
                if (c.trans == HTRANS_SEQ) begin
                    h.trans = HTRANS_NONSEQ; h.burst = HBURST_INCR;
                end
                m_parked = 1; m_park = h;
            end
        end
    endtask

    always begin
        exp_t e;
        @(negedge HCLK);
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("sel_ip", 32'(bus.sel_ip), 32'(e.ctl.sel));
            chk("addr_ip", bus.addr_ip, e.ctl.addr);
            chk("auser_ip", bus.auser_ip, e.ctl.auser);
            chk("trans_ip", 32'(bus.trans_ip), 32'(e.ctl.trans));
            chk("write_ip", 32'(bus.write_ip), 32'(e.ctl.write));
            chk("size_ip", 32'(bus.size_ip), 32'(e.ctl.size));
            chk("burst_ip", 32'(bus.burst_ip), 32'(e.ctl.burst));
            chk("prot_ip", 32'(bus.prot_ip), 32'(e.ctl.prot));
            chk("master_ip", 32'(bus.master_ip), 32'(e.ctl.master));
            chk("mastlock_ip", 32'(bus.mastlock_ip), 32'(e.ctl.mastlock));
            chk("wdata_ip", bus.wdata_ip, e.wdata);
            chk("wuser_ip", bus.wuser_ip, e.wuser);
            chk("held_tran_ip", 32'(bus.held_tran_ip), 32'(e.held_tran));
            chk("HREADYOUTS", 32'(bus.HREADYOUTS), 32'(e.hreadyout));
            chk("HRESPS", 32'(bus.HRESPS), 32'(e.hresp));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run still going at %0t, required to end", $time);
        $fatal(1, "timeout");
    end

    initial begin
        ctl_t idl;
        ctl_t c;
        idl = mk(1'b1, 32'h0, HTRANS_IDLE, 1'b0, 3'b000);
        m_parked = 0; m_busy = 0; m_park = '0;
        apply(idl, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, HRESP_OKAY);
        #1;
        chk("rst_HREADYOUTS", 32'(bus.HREADYOUTS), 32'd1);
        chk("rst_HRESPS", 32'(bus.HRESPS), 32'(HRESP_OKAY));
        chk("rst_held_tran", 32'(bus.held_tran_ip), 32'd0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;

        // NONSEQ write granted at once, slave waits two cycles.
        cyc(mk(1, 32'h2000_0000, HTRANS_NONSEQ, 1, 3'b000), 32'h1111, 32'h1, 1, 1, 1, HRESP_OKAY);
        cyc(idl, 32'hDEAD_0001, 32'h2, 0, 0, 0, HRESP_OKAY);
        cyc(idl, 32'hDEAD_0001, 32'h2, 0, 0, 0, HRESP_OKAY);
        cyc(idl, 32'hDEAD_0001, 32'h2, 0, 0, 1, HRESP_OKAY);

        // NONSEQ read parked for three cycles while the master wanders.
        cyc(mk(1, 32'h2000_0010, HTRANS_NONSEQ, 0, 3'b000), 32'h0, 32'h0, 0, 1, 1, HRESP_OKAY);
        c = mk(1, 32'h3000_0000, HTRANS_NONSEQ, 1, 3'b000);
        repeat (3) cyc(c, 32'h0, 32'h0, 0, 1, 1, HRESP_OKAY);
        cyc(c, 32'h0, 32'h0, 1, 1, 1, HRESP_OKAY);
        cyc(idl, 32'h0, 32'h0, 0, 0, 1, HRESP_OKAY);

        // SEQ beat of INCR4 parked one cycle.
        c = mk(1, 32'h0000_0008, HTRANS_SEQ, 0, 3'b011);
        cyc(c, 32'h0, 32'h0, 0, 1, 1, HRESP_OKAY);
        cyc(c, 32'h0, 32'h0, 0, 1, 1, HRESP_OKAY);
        cyc(c, 32'h0, 32'h0, 1, 1, 1, HRESP_OKAY);
        cyc(idl, 32'h0, 32'h0, 0, 0, 1, HRESP_OKAY);

        // Two-cycle ERROR response, then idle.
        cyc(mk(1, 32'h4000_0000, HTRANS_NONSEQ, 1, 3'b000), 32'h0, 32'h0, 1, 1, 1, HRESP_OKAY);
        cyc(idl, 32'h5, 32'h0, 0, 0, 0, HRESP_ERROR);
        cyc(idl, 32'h5, 32'h0, 0, 0, 1, HRESP_ERROR);
        cyc(idl, 32'h0, 32'h0, 0, 0, 1, HRESP_OKAY);

        // BUSY and IDLE selected: zero-wait OKAY, no request.
        cyc(mk(1, 32'h5000_0000, HTRANS_BUSY, 0, 3'b001), 32'h0, 32'h0, 0, 0, 0, HRESP_ERROR);
        cyc(mk(1, 32'h5000_0004, HTRANS_IDLE, 0, 3'b001), 32'h0, 32'h0, 1, 1, 0, HRESP_ERROR);

        // Async reset while a transfer is parked.
        cyc(mk(1, 32'h6000_0000, HTRANS_NONSEQ, 1, 3'b000), 32'h0, 32'h0, 0, 1, 1, HRESP_OKAY);
        @(negedge HCLK);
        apply(idl, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, HRESP_OKAY);
        #3;
        chk("hold_HREADYOUTS", 32'(bus.HREADYOUTS), 32'd0);
        chk("hold_held_tran", 32'(bus.held_tran_ip), 32'd1);
        HRESETn = 1'b0;
        #1;
        chk("arst_HREADYOUTS", 32'(bus.HREADYOUTS), 32'd1);
        chk("arst_held_tran", 32'(bus.held_tran_ip), 32'd0);
        chk("arst_HRESPS", 32'(bus.HRESPS), 32'(HRESP_OKAY));
        chk("arst_hold_addr", dut.u_hold.addr_q, 32'h0);
        chk("arst_hold_sel", 32'(dut.u_hold.sel_q), 32'd0);
        m_parked = 0; m_busy = 0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        cyc(mk(1, 32'h7000_0000, HTRANS_NONSEQ, 0, 3'b000), 32'h0, 32'h0, 1, 1, 0, HRESP_OKAY);
        cyc(idl, 32'h0, 32'h0, 0, 0, 1, HRESP_OKAY);

        for (int i = 0; i < 600; i++) begin
            c.sel = ($urandom_range(7) != 0);
            c.addr = $urandom;  c.auser = $urandom;
            c.trans = 2'($urandom_range(3)); c.write = 1'($urandom);
            c.size = 3'($urandom_range(2)); c.burst = 3'($urandom);
            c.prot = 4'($urandom); c.master = 4'($urandom);
            c.mastlock = ($urandom_range(5) == 0);
            cyc(c, $urandom, $urandom,
                ($urandom_range(2) != 0), ($urandom_range(3) != 0),
                ($urandom_range(2) != 0),
                ($urandom_range(7) == 0) ? HRESP_ERROR : HRESP_OKAY);
        end

        repeat (3) @(negedge HCLK);
        if (q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb_mtx_input_stage.md
Name: ahb_mtx_input_stage

Overview:
Per-master slave-port front end of the L1 AHB bus matrix. It sits between one master layer and all output stages of the matrix. It feeds each output stage the port's address/control, write data and a held_tran request. When no output stage grants the port, it captures the address phase in a holding register and stalls the master. Data-phase HREADYOUT/HRESP are returned from the granting path.

Parameters:
AW, 32, address width
UW, 32, HAUSER/HWUSER width
DW, 32, write data width

Ports:
HCLK  in  1  AHB clock
HRESETn  in  1  async active-low reset
HSELS  in  1  layer select for this port
HADDRS  in  AW  master address
HAUSERS  in  UW  address user bus
HTRANSS  in  2  transfer type
HWRITES  in  1  direction
HSIZES  in  3  size
HBURSTS  in  3  burst
HPROTS  in  4  protection
HMASTERS  in  4  master ID
HMASTLOCKS  in  1  locked
HWDATAS  in  DW  write data
HWUSERS  in  UW  write user
HREADYS  in  1  layer HREADY
HREADYOUTS  out  1  ready to master
HRESPS  out  2  response to master
sel_ip, addr_ip, auser_ip, trans_ip, write_ip, size_ip, burst_ip, prot_ip, master_ip, mastlock_ip  out  (widths as master side)  address/control to output stages
wdata_ip  out  DW  write data to output stages
wuser_ip  out  UW  write user to output stages
held_tran_ip  out  1  valid transfer request
active_ip  in  1  OR of this port's active_opN over all output stages
hreadymux_ip  in  1  HREADYMUX of the output stage granting this port
readyout_ip  in  1  HREADYOUT of the slave owning this port's data phase
resp_ip  in  2  HRESP of that slave

Behaviour:
- Clock/reset (already decided): single clock HCLK; HRESETn asynchronous, active-low.
- trans_req = HSELS & HTRANSS[1] & HREADYS (NONSEQ/SEQ only); accept = active_ip & hreadymux_ip.
- States:
  - IDLE: no transfer outstanding.
  - HOLD: address phase captured, not yet granted.
  - DATA: data phase in flight at a slave.
- Reset: state=IDLE, hold registers=0, HREADYOUTS=1, HRESPS=OKAY(2'b00), held_tran_ip=0.
- IDLE / DATA-completing cycle:
  - trans_req & accept -> DATA next cycle; zero added latency.
  - trans_req & ~accept -> capture all address/control into hold regs -> HOLD.
  - no trans_req -> IDLE.
  - In DATA, a new trans_req can only occur when readyout_ip=1, via HREADYS.
- Address-side outputs:
  - HOLD: driven from hold regs; held_tran_ip=1.
  - Otherwise: live master signals; held_tran_ip=trans_req.
- HOLD conversion: a captured SEQ is presented as trans_ip=NONSEQ(2'b10), burst_ip=INCR(3'b001). A captured NONSEQ is presented unchanged.
- HOLD behaviour: HREADYOUTS=0, HRESPS=OKAY. Leaves to DATA on the first cycle accept=1. HREADYS=1 with trans_req in HOLD is illegal (assert).
- DATA behaviour:
  - HREADYOUTS=readyout_ip, HRESPS=resp_ip.
  - Two-cycle ERROR passes through unmodified: cycle 1 (ERROR, 0), cycle 2 (ERROR, 1).
  - Next state decided only when readyout_ip=1.
- IDLE/BUSY, or HSELS=0: zero-wait OKAY, no request. mastlock_ip still reflects HMASTLOCKS so output-stage lock tracking holds.
- Write data: wdata_ip/wuser_ip = HWDATAS/HWUSERS, combinational. The master holds data stable for the whole data phase, so no register is needed.
- Async reset mid-HOLD or mid-DATA: immediately returns to reset values and drops the captured transfer.

Decomposition:
- Package ahb_mtx_pkg:
  - HTRANS encodings: IDLE, BUSY, NONSEQ, SEQ.
  - HBURST_INCR.
  - HRESP OKAY/ERROR.
  - State encoding: IDLE=2'b00, HOLD=2'b01, DATA=2'b10.
- One sub-module, ahb_mtx_hold_reg: capture register plus SEQ->NONSEQ/INCR rewrite and live/held output mux. The FSM stays in the top.

Test Plan:
- NONSEQ write to 0x2000_0000 with active_ip=1, hreadymux_ip=1 -> held_tran_ip=1 same cycle, state DATA next. readyout_ip=0,0,1 -> HREADYOUTS=0,0,1.
- NONSEQ read to 0x2000_0010, active_ip=0 for 3 cycles, master moves HADDRS to 0x3000_0000 -> addr_ip stays 0x2000_0010, HREADYOUTS=0 for 3 cycles. On grant, DATA next cycle.
- SEQ beat of INCR4 at 0x0000_0008 held for 1 cycle -> trans_ip=2'b10, burst_ip=3'b001 while held.
- In DATA, resp_ip/readyout_ip = (ERROR,0) then (ERROR,1) -> HRESPS/HREADYOUTS mirror exactly; master then drives IDLE -> state IDLE.
- HTRANSS=BUSY and IDLE with HSELS=1 -> held_tran_ip=0, HREADYOUTS=1, HRESPS=OKAY each cycle.
- HRESETn low during HOLD -> held_tran_ip=0, HREADYOUTS=1 asynchronously. After release, state IDLE and hold regs zero.
